inst_fetch_unit: RTL
====================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter DATA_W, 32, instruction word width in bits.
REQ-002 Parameter ADDR_W, 32, PC width in bits; the PC is word-addressed.
REQ-003 Parameter DEPTH, 1024, memory words; power of two, at least 2.
REQ-004 Parameter QDEPTH, 2, fetch-queue entries; at least 2.
REQ-005 Parameter RESET_PC, 0, PC value after reset.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 load_en  in  1  write load_data into memory this cycle.
REQ-009 load_addr  in  ADDR_W  write word address; the low log2(DEPTH) bits are used.
REQ-010 load_data  in  DATA_W  word to write.
REQ-011 redirect  in  1  branch/jump: flush the queue and restart at redirect_pc.
REQ-012 redirect_pc  in  ADDR_W  new fetch PC.
REQ-013 inst_ready  in  1  decode accepts the head of the queue.
REQ-014 inst_valid  out  1  queue head is valid.
REQ-015 inst  out  DATA_W  instruction word at the queue head.
REQ-016 inst_pc  out  ADDR_W  PC of the queue-head instruction.
REQ-017 inst_perr  out  1  parity error on the queue-head word.
REQ-018 fetch_pc  out  ADDR_W  PC of the next fetch to be issued.

Function
REQ-019 Memory read is synchronous: an address issued in cycle N returns data that enters the queue at the end of cycle N+1.
REQ-020 A fetch issues in a cycle only if queue occupancy plus in-flight reads, minus a pop this cycle, is less than QDEPTH, and redirect is low.
REQ-021 Each issued fetch increments fetch_pc by 1, wrapping modulo 2^ADDR_W; memory index is fetch_pc mod DEPTH.
REQ-022 A pop occurs when inst_valid and inst_ready are both high; the queue is FIFO-ordered, and inst, inst_pc and inst_perr hold stable while inst_valid is high and inst_ready is low.
REQ-023 With the queue empty, an arriving word is visible on the inst port in the same cycle it is written to the queue (zero-bubble) only if the team's bypass is built; otherwise the word is visible one cycle later. The first word after reset reaches inst_valid=1 exactly 2 cycles after rst falls.
REQ-024 Redirect: in the same edge, the queue is emptied, in-flight reads are discarded, and fetch_pc <= redirect_pc; fetching resumes the next cycle. Redirect overrides any pop or fill in that cycle.
REQ-025 Load and fetch to the same index in the same cycle: the fetch returns the old word (read-first); the new word is visible to later fetches.
REQ-026 Loads are accepted every cycle regardless of queue state or redirect.
REQ-027 Simultaneous push and pop when the queue is full is legal, and occupancy is unchanged.

Reset
REQ-028 While rst is high: fetch_pc=RESET_PC, queue empty, in-flight cleared, inst_valid=0, inst_perr=0, and inst and inst_pc are driven to 0; memory contents are unchanged.
REQ-029 A reset asserted mid-operation drops all queued and in-flight fetches within that cycle.

Configuration
REQ-030 Macro IFU_PARITY_EN defined: each memory word stores one extra even-parity bit computed on load; on read, inst_perr=1 if the recomputed parity mismatches, and it travels with the queue entry.
REQ-031 Macro IFU_PARITY_EN undefined: no parity storage is built, and inst_perr is tied to 0.

Structure
REQ-032 Package ifu_pkg holds the default parameter constants, the queue-entry typedef (data, pc, perr), and the parity function.
REQ-033 Sub-module ifu_inst_ram provides a single-write-port, single-sync-read-port, read-first RAM of DEPTH x (DATA_W + parity) bits.

Verification
REQ-034 Load 0x5D4575DF @ 0x10, 0x5D4575DC @ 0x11, 0x5D4575D0 @ 0x12; RESET_PC=0x10; release rst with inst_ready=1 -> words appear in order with inst_pc 0x10, 0x11, 0x12, the first 2 cycles after rst falls, then one per cycle.
REQ-035 inst_ready=0 for 10 cycles -> at most QDEPTH entries are held, fetch_pc stops at 0x10+QDEPTH, and no word is lost or duplicated after inst_ready rises.
REQ-036 redirect=1, redirect_pc=0x12 while the queue is full -> next cycle inst_valid=0; the first valid word after that is 0x5D4575D0 with inst_pc 0x12.
REQ-037 load_en to 0x11 with 0xFFFFFFFF in the same cycle as a fetch of 0x11 -> that fetch returns 0x5D4575DC, and a refetch after redirect returns 0xFFFFFFFF.
REQ-038 fetch_pc=DEPTH-1 -> the next fetch reads index 0 with inst_pc=DEPTH; rst pulsed mid-stream -> inst_valid=0 next cycle and fetch restarts at RESET_PC.
REQ-039 With IFU_PARITY_EN defined, force one stored bit flip at 0x11 -> inst_perr=1 only on the 0x11 entry.

Source files
------------

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared constants, queue-entry type and parity helper for the fetch unit
//
// Purpose: default parameter values for inst_fetch_unit, the fetch-queue entry
// typedef (data, pc, perr) and the even-parity function.
// Entry fields are sized for the widest supported configuration (64 bits);
// narrower builds use only the low bits and leave the rest at zero.
// Optional feature macro: IFU_PARITY_EN (the parity function is only called then).
package ifu_pkg;

  localparam int IFU_DATA_W   = 32;
  localparam int IFU_ADDR_W   = 32;
  localparam int IFU_DEPTH    = 1024;
  localparam int IFU_QDEPTH   = 2;
  localparam int IFU_RESET_PC = 0;
  localparam int IFU_MAX_W    = 64;

  typedef struct packed {
    logic [IFU_MAX_W-1:0] data;
    logic [IFU_MAX_W-1:0] pc;
    logic                 perr;
  } ifu_entry_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic ifu_parity(input logic [IFU_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ifu_inst_ram.sv
// rtl/ifu_inst_ram.sv - single-write, single-sync-read, read-first instruction RAM
//
// Purpose: DEPTH x WIDTH storage. The read port registers the word at raddr_i
// every cycle; a write to the same index in the same cycle is not seen by that
// read (old word returned), only by later reads.
// Ports:
//   clk_i    in   clock
//   we_i     in   write enable
//   waddr_i  in   write index
//   wdata_i  in   write word
//   raddr_i  in   read index
//   rdata_o  out  registered read word (valid the cycle after raddr_i)
module ifu_inst_ram #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Contents survive reset by design; the read register is qualified by the
  // caller's in-flight flag, so it needs no reset either.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch unit with sync RAM and small fetch queue
//
// Purpose: issues sequential word fetches from fetch_pc into a synchronous RAM,
// collects the returning words in a QDEPTH-entry FIFO and presents the head to
// decode with a valid/ready handshake. Redirect flushes and restarts fetching.
// Optional feature macro: IFU_PARITY_EN (per-word even parity, reported on inst_perr).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_en/addr/data        RAM write port, accepted every cycle
//   redirect, redirect_pc    flush queue and in-flight read, restart at redirect_pc
//   inst_ready               decode accepts the queue head
//   inst_valid/inst/inst_pc  queue head (zeroed when empty)
//   inst_perr                parity error on the queue head
//   fetch_pc                 PC of the next fetch to be issued
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                DATA_W   = IFU_DATA_W,
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                DEPTH    = IFU_DEPTH,
  parameter int                QDEPTH   = IFU_QDEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_perr,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
`ifdef IFU_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int RAM_W = DATA_W + PAR_W;

  logic [RAM_W-1:0]  ram_wdata;
  logic [RAM_W-1:0]  ram_rdata;

  ifu_entry_t        queue_q [QDEPTH];
  ifu_entry_t        push_entry;
  ifu_entry_t        head;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] flight_pc_q, flight_pc_d;
  logic              inflight_q, inflight_d;

  logic              q_nonempty;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    occ_after;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------- RAM
`ifdef IFU_PARITY_EN
  logic [IFU_MAX_W-1:0] load_ext;
  always_comb begin
    load_ext                = '0;
    load_ext[DATA_W-1:0]    = load_data;
    ram_wdata               = {ifu_parity(load_ext), load_data};
  end
`else
  assign ram_wdata = load_data;
`endif

  ifu_inst_ram #(
    .WIDTH (RAM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (load_en),
    .waddr_i (load_addr[IDX_W-1:0]),
    .wdata_i (ram_wdata),
    .raddr_i (fetch_pc_q[IDX_W-1:0]),
    .rdata_o (ram_rdata)
  );

  // ------------------------------------------------------- queue entry
`ifdef IFU_PARITY_EN
  logic [IFU_MAX_W-1:0] rd_ext;
`endif
  always_comb begin
    push_entry                  = '0;
    push_entry.data[DATA_W-1:0] = ram_rdata[DATA_W-1:0];
    push_entry.pc[ADDR_W-1:0]   = flight_pc_q;
`ifdef IFU_PARITY_EN
    rd_ext                      = '0;
    rd_ext[DATA_W-1:0]          = ram_rdata[DATA_W-1:0];
    push_entry.perr             = ifu_parity(rd_ext) ^ ram_rdata[DATA_W];
`endif
  end

  // ------------------------------------------------------ control path
  always_comb begin
    q_nonempty  = (count_q != '0);
    pop         = q_nonempty && inst_ready;
    // The read issued last cycle lands in the queue at the end of this one.
    push        = inflight_q;
    // Occupancy after this cycle's pop, counting the read still in flight;
    // a new fetch must fit behind everything already committed.
    occ_after   = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    issue       = !redirect && (occ_after < (CNT_W + 1)'(QDEPTH));

    fetch_pc_d  = fetch_pc_q;
    flight_pc_d = flight_pc_q;
    inflight_d  = inflight_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;

    if (redirect) begin
      // Overrides any pop or fill this cycle.
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      inflight_d  = issue;
      flight_pc_d = fetch_pc_q;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      flight_pc_q <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      flight_pc_q <= flight_pc_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Entry storage is qualified by count_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && !redirect && push) begin
      queue_q[wr_ptr_q] <= push_entry;
    end
  end

  // ----------------------------------------------------------- outputs
  assign head       = queue_q[rd_ptr_q];
  assign inst_valid = q_nonempty;
  assign inst       = q_nonempty ? head.data[DATA_W-1:0] : '0;
  assign inst_pc    = q_nonempty ? head.pc[ADDR_W-1:0]   : '0;
`ifdef IFU_PARITY_EN
  assign inst_perr  = q_nonempty && head.perr;
`else
  assign inst_perr  = 1'b0;
`endif
  assign fetch_pc   = fetch_pc_q;

  // Upper entry bits and upper load-address bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{head, load_addr};

endmodule
